// File: rtl/veggie_gfx_pkg.sv
// Shared graphics constants and types for the frame displayer / frame blitter pair.
// The frame buffer is 640x480, 8-bit pixels, addressed as y*H_RES + x.
package veggie_gfx_pkg;

   localparam int H_RES   = 640;
   localparam int V_RES   = 480;
   localparam int ADDR_W  = 19;
   localparam int COLOR_W = 8;

   typedef enum logic {
      BLIT_FILL  = 1'b0,
      BLIT_CLEAR = 1'b1
   } blit_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } blit_state_t;

   // y*640 as (y<<9)+(y<<7) so no multiplier is needed
   function automatic logic [ADDR_W-1:0] row_offset(input logic [9:0] y);
      logic [ADDR_W-1:0] y_ext;
      y_ext = ADDR_W'(y);
      return (y_ext << 9) + (y_ext << 7);
   endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Raster-order address generator for the frame blitter: col/row counters plus a row_base
// accumulator; emits one registered address per cycle while pixel_valid is high.
module blit_addr_gen
   import veggie_gfx_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              start,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic [9:0]        w_eff,
   input  logic [9:0]        h_eff,
   output logic [ADDR_W-1:0] addr,
   output logic              pixel_valid,
   output logic              last
);

   logic [9:0]        x_q;
   logic [9:0]        w_q;
   logic [9:0]        h_q;
   logic [9:0]        col;
   logic [9:0]        row;
   logic [ADDR_W-1:0] row_base;

   logic [9:0]        w_last;
   logic [9:0]        h_last;
   logic [9:0]        col_nxt;
   logic [9:0]        row_nxt;
   logic              row_end;
   logic              final_row;
   logic [ADDR_W-1:0] next_row_base;
   logic [ADDR_W-1:0] start_base;

   assign w_last        = w_q - 10'd1;
   assign h_last        = h_q - 10'd1;
   assign col_nxt       = col + 10'd1;
   assign row_nxt       = row + 10'd1;
   assign row_end       = (col == w_last);
   assign final_row     = (row == h_last);
   assign next_row_base = row_base + ADDR_W'(H_RES);
   assign start_base    = row_offset(y);

   // addr is kept one step ahead so the write port sees a registered address every cycle
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_q         <= '0;
         w_q         <= '0;
         h_q         <= '0;
         col         <= '0;
         row         <= '0;
         row_base    <= '0;
         addr        <= '0;
         pixel_valid <= 1'b0;
         last        <= 1'b0;
      end else if (start) begin
         x_q         <= x;
         w_q         <= w_eff;
         h_q         <= h_eff;
         col         <= '0;
         row         <= '0;
         row_base    <= start_base;
         addr        <= start_base + ADDR_W'(x);
         pixel_valid <= (w_eff != 10'd0) && (h_eff != 10'd0);
         last        <= (w_eff == 10'd1) && (h_eff == 10'd1);
      end else if (pixel_valid) begin
         if (row_end) begin
            if (final_row) begin
               pixel_valid <= 1'b0;
               last        <= 1'b0;
            end else begin
               col      <= '0;
               row      <= row_nxt;
               row_base <= next_row_base;
               addr     <= next_row_base + ADDR_W'(x_q);
               last     <= (row_nxt == h_last) && (w_q == 10'd1);
            end
         end else begin
            col  <= col_nxt;
            addr <= addr + ADDR_W'(1);
            last <= (col_nxt == w_last) && final_row;
         end
      end
   end

endmodule

// File: rtl/frame_blitter.sv
// Rectangle fill / screen clear engine writing the 640x480 frame buffer one pixel per clock.
// Optional on-screen clipping is enabled by defining FRAME_BLIT_CLIP_EN.
module frame_blitter
   import veggie_gfx_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_op,
   input  logic [9:0]         cmd_x,
   input  logic [9:0]         cmd_y,
   input  logic [9:0]         cmd_w,
   input  logic [9:0]         cmd_h,
   input  logic [COLOR_W-1:0] cmd_color,
   output logic [ADDR_W-1:0]  frame_wrAddress,
   output logic [COLOR_W-1:0] frame_input,
   output logic               frame_we,
   output logic               busy,
   output logic               done
);

   blit_state_t state;
   blit_state_t next_state;

   logic [9:0] x_q;
   logic [9:0] y_q;
   logic [9:0] w_q;
   logic [9:0] h_q;
   logic [9:0] w_eff;
   logic [9:0] h_eff;
   logic       empty;
   logic       accept;
   logic       gen_start;
   logic       gen_valid;
   logic       gen_last;

   assign accept    = (state == IDLE) && cmd_valid;
   assign gen_start = (state == SETUP);
   assign empty     = (w_eff == 10'd0) || (h_eff == 10'd0);

`ifdef FRAME_BLIT_CLIP_EN
   logic [10:0] room_x;
   logic [10:0] room_y;

   assign room_x = 11'(H_RES) - {1'b0, x_q};
   assign room_y = 11'(V_RES) - {1'b0, y_q};

   // Trim the rectangle to the visible area; fully off-screen commands become empty
   always_comb begin
      w_eff = '0;
      h_eff = '0;
      if ({1'b0, x_q} < 11'(H_RES))
         w_eff = ({1'b0, w_q} < room_x) ? w_q : room_x[9:0];
      if ({1'b0, y_q} < 11'(V_RES))
         h_eff = ({1'b0, h_q} < room_y) ? h_q : room_y[9:0];
   end
`else
   assign w_eff = w_q;
   assign h_eff = h_q;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         state     <= next_state;
         busy      <= (next_state != IDLE);
         done      <= (next_state == DONE);
         cmd_ready <= (next_state == IDLE);
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (cmd_valid) next_state = SETUP;
         SETUP:   next_state = empty ? DONE : FILL;
         FILL:    if (!gen_valid || gen_last) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Command fields are captured only at accept; CLEAR is just a full-screen FILL
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_q         <= '0;
         y_q         <= '0;
         w_q         <= '0;
         h_q         <= '0;
         frame_input <= '0;
      end else if (accept) begin
         frame_input <= cmd_color;
         if (blit_op_t'(cmd_op) == BLIT_CLEAR) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= 10'(H_RES);
            h_q <= 10'(V_RES);
         end else begin
            x_q <= cmd_x;
            y_q <= cmd_y;
            w_q <= cmd_w;
            h_q <= cmd_h;
         end
      end
   end

   blit_addr_gen u_addr_gen (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .start       (gen_start),
      .x           (x_q),
      .y           (y_q),
      .w_eff       (w_eff),
      .h_eff       (h_eff),
      .addr        (frame_wrAddress),
      .pixel_valid (gen_valid),
      .last        (gen_last)
   );

   assign frame_we = gen_valid;

endmodule
